// File: rtl/fir_tap_sequencer.sv
// Time-multiplexed FIR tap sequencer that feeds an external pipelined multiply-accumulate unit.
// Define FIR_ROUND_SAT_EN for a rounded, saturated output; otherwise the output is truncated.

module fir_tap_sequencer #(
    parameter int unsigned NTAPS     = 32,
    parameter int unsigned MAC_LAT   = 3,
    parameter int unsigned COEF_FRAC = 17
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [23:0]              in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     coef_we,
    input  logic [$clog2(NTAPS)-1:0] coef_addr,
    input  logic [17:0]              coef_data,
    output logic [24:0]              mac_a,
    output logic [17:0]              mac_b,
    output logic [47:0]              mac_c,
    input  logic [47:0]              mac_out,
    input  logic                     mac_valid,
    output logic [23:0]              out_data,
    output logic                     out_valid,
    output logic                     err
);

    localparam int unsigned AW    = $clog2(NTAPS);
    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned CW    = $clog2(NTAPS + MAC_LAT) + 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StOut
    } state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        newest_q, newest_d;
    logic [47:0]          acc_q, acc_d;
    logic [23:0]          out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic                 err_q, err_d;
    logic [MAC_LAT-1:0]   pipe_q, pipe_d;
    logic [3:0]           ign_q, ign_d;

    logic [23:0]          dline_q [DEPTH];
    logic [17:0]          coef_q  [DEPTH];

    logic                 dl_we;
    logic                 coef_wr;
    logic [AW-1:0]        tap_k;
    logic [AW-1:0]        rd_idx;
    logic [47:0]          acc_sum;
    logic [23:0]          fmt_data;
    logic                 issue;

    assign tap_k   = cnt_q[AW-1:0];
    assign acc_sum = acc_q + mac_out;
    assign issue   = (state_q == StRun);

    // Tap k reads the sample k steps older than the newest one, wrapping around the ring.
    always_comb begin
        if (newest_q >= tap_k) begin
            rd_idx = newest_q - tap_k;
        end else begin
            rd_idx = AW'({1'b0, newest_q} + (AW+1)'(NTAPS) - {1'b0, tap_k});
        end
    end

`ifdef FIR_ROUND_SAT_EN
    logic signed [48:0] rnd_full;
    logic signed [48:0] rnd_shift;

    always_comb begin
        rnd_full  = $signed({acc_sum[47], acc_sum}) + (49'sd1 <<< (COEF_FRAC - 1));
        rnd_shift = rnd_full >>> COEF_FRAC;
        if (rnd_shift > 49'sd8388607) begin
            fmt_data = 24'h7fffff;
        end else if (rnd_shift < -49'sd8388608) begin
            fmt_data = 24'h800000;
        end else begin
            fmt_data = rnd_shift[23:0];
        end
    end
`else
    always_comb begin
        fmt_data = acc_sum[COEF_FRAC+23:COEF_FRAC];
    end
`endif

    // MAC operands are live only while taps are being issued.
    always_comb begin
        mac_a = '0;
        mac_b = '0;
        mac_c = '0;
        if (state_q == StRun) begin
            mac_a = {dline_q[rd_idx][23], dline_q[rd_idx]};
            mac_b = coef_q[tap_k];
            if (cnt_q >= CW'(MAC_LAT)) begin
                mac_c = mac_out;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_ptr_d    = wr_ptr_q;
        newest_d    = newest_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        dl_we       = 1'b0;
        coef_wr     = 1'b0;

        unique case (state_q)
            StIdle: begin
                coef_wr = coef_we;
                if (in_valid) begin
                    dl_we    = 1'b1;
                    newest_d = wr_ptr_q;
                    wr_ptr_d = (wr_ptr_q == AW'(NTAPS - 1)) ? '0 : wr_ptr_q + 1'b1;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                if (cnt_q == CW'(NTAPS - 1)) begin
                    cnt_d   = '0;
                    state_d = StDrain;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDrain: begin
                acc_d = acc_sum;
                if (cnt_q == CW'(MAC_LAT - 1)) begin
                    out_data_d  = fmt_data;
                    out_valid_d = 1'b1;
                    state_d     = StOut;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StOut: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // The issue shift register predicts mac_valid; after a reset, results still in flight
    // inside the MAC are masked for MAC_LAT cycles so they cannot raise err.
    always_comb begin
        pipe_d = MAC_LAT'({pipe_q, issue});
        ign_d  = (ign_q != '0) ? ign_q - 1'b1 : '0;
        err_d  = err_q | ((ign_q == '0) && (mac_valid != pipe_q[MAC_LAT-1]));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            newest_q    <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            pipe_q      <= '0;
            ign_q       <= 4'(MAC_LAT);
            for (int i = 0; i < DEPTH; i++) begin
                dline_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            newest_q    <= newest_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            pipe_q      <= pipe_d;
            ign_q       <= ign_d;
            if (dl_we) begin
                dline_q[wr_ptr_q] <= in_data;
            end
        end
    end

    // Coefficients survive reset.
    always_ff @(posedge clk) begin
        if (coef_wr) begin
            coef_q[coef_addr] <= coef_data;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign err       = err_q;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed bench for fir_tap_sequencer with a behavioural MAC of latency ML.
// Expected outputs are hand-computed for NTAPS=32, MAC_LAT=3, COEF_FRAC=17.

module tb_fir_tap_sequencer;

    localparam int NT     = 32;
    localparam int ML     = 3;
    localparam int PERIOD = NT + ML + 2;

`ifdef FIR_ROUND_SAT_EN
    localparam logic [23:0] SAT_EXP = 24'h7fffff;
`else
    localparam logic [23:0] SAT_EXP = 24'hfff7e0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        coef_we = 1'b0;
    logic [4:0]  coef_addr = '0;
    logic [17:0] coef_data = '0;
    logic [24:0] mac_a;
    logic [17:0] mac_b;
    logic [47:0] mac_c;
    logic [47:0] mac_out;
    logic        mac_valid;
    logic [23:0] out_data;
    logic        out_valid;
    logic        err;

    fir_tap_sequencer #(
        .NTAPS    (NT),
        .MAC_LAT  (ML),
        .COEF_FRAC(17)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .coef_we  (coef_we),
        .coef_addr(coef_addr),
        .coef_data(coef_data),
        .mac_a    (mac_a),
        .mac_b    (mac_b),
        .mac_c    (mac_c),
        .mac_out  (mac_out),
        .mac_valid(mac_valid),
        .out_data (out_data),
        .out_valid(out_valid),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Behavioural MAC: result a*b+c appears ML cycles after issue.
    logic [47:0]        mval [ML] = '{default: 48'd0};
    logic               mv   [ML] = '{default: 1'b0};
    int                 icnt = 0;
    logic               kill = 1'b0;
    logic signed [47:0] a48, b48, mres;

    assign a48       = {{23{mac_a[24]}}, mac_a};
    assign b48       = {{30{mac_b[17]}}, mac_b};
    assign mres      = a48 * b48 + $signed(mac_c);
    assign mac_out   = mval[ML-1];
    assign mac_valid = mv[ML-1] & ~kill;

    always @(posedge clk) begin
        mv[0]   <= (icnt > 0);
        mval[0] <= mres;
        for (int i = 1; i < ML; i++) begin
            mv[i]   <= mv[i-1];
            mval[i] <= mval[i-1];
        end
        if (rst) icnt <= 0;
        else if (in_valid && in_ready) icnt <= NT;
        else if (icnt > 0) icnt <= icnt - 1;
    end

    int          cyc = 0;
    logic [23:0] outq [$];
    int          tq   [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            outq.push_back(out_data);
            tq.push_back(cyc);
        end
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic send(input logic [23:0] d);
        int n = 0;
        in_data  = d;
        in_valid = 1'b1;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 4 * PERIOD) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) check("accept_timeout", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic write_coef(input int addr, input logic [17:0] data);
        coef_we   = 1'b1;
        coef_addr = 5'(addr);
        coef_data = data;
        @(posedge clk);
        #1;
        coef_we = 1'b0;
    endtask

    task automatic clear_q();
        outq.delete();
        tq.delete();
    endtask

    task automatic wait_outs(input int n, input string tag);
        int t = 0;
        while (outq.size() < n && t < n * PERIOD + 200) begin
            @(negedge clk);
            t++;
        end
        repeat (5) @(negedge clk);
        check({tag, "_count"}, outq.size(), n);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_err", err, 0);
        check("rst_mac_a", mac_a, 0);
        check("rst_mac_b", mac_b, 0);
        check("rst_mac_c", mac_c, 0);

        // Impulse: outputs walk through the coefficients 1..NT.
        for (int k = 0; k < NT; k++) write_coef(k, 18'(k + 1));
        clear_q();
        for (int j = 0; j < NT; j++) begin
            send(j == 0 ? 24'd131072 : 24'd0);
            if (j == 0) begin
                check("tap0_mac_a", mac_a, 25'h0020000);
                check("tap0_mac_b", mac_b, 1);
                check("tap0_mac_c", mac_c, 0);
                check("run_in_ready", in_ready, 0);
            end
        end
        wait_outs(NT, "impulse");
        for (int j = 0; j < outq.size() && j < NT; j++) begin
            check("impulse_out", outq[j], 24'(j + 1));
            if (j > 0) check("impulse_gap", tq[j] - tq[j-1], PERIOD);
        end
        check("impulse_err", err, 0);

        // Reset at tap 10 aborts the frame; a fresh impulse gives the first-run result.
        pulse_rst();
        clear_q();
        send(24'd131072);
        repeat (10) @(posedge clk);
        #1;
        check("abort_busy", in_ready, 0);
        pulse_rst();
        check("abort_in_ready", in_ready, 1);
        check("abort_out_data", out_data, 0);
        check("abort_mac_a", mac_a, 0);
        repeat (50) @(negedge clk);
        check("abort_no_out", outq.size(), 0);
        check("abort_err", err, 0);
        send(24'd131072);
        wait_outs(1, "rerun");
        if (outq.size() > 0) check("rerun_out", outq[0], 1);

        // A coefficient write during RUN is dropped; coefficients also survive reset.
        pulse_rst();
        clear_q();
        send(24'd131072);
        coef_we   = 1'b1;
        coef_addr = 5'd0;
        coef_data = 18'd500;
        @(posedge clk);
        #1;
        coef_we = 1'b0;
        wait_outs(1, "runwr");
        pulse_rst();
        clear_q();
        send(24'd131072);
        wait_outs(1, "coefkeep");
        if (outq.size() > 0) check("coefkeep_out", outq[0], 1);

        // Coefficient write together with sample acceptance is used by that run.
        pulse_rst();
        clear_q();
        coef_we   = 1'b1;
        coef_addr = 5'd0;
        coef_data = 18'd7;
        send(24'd131072);
        coef_we = 1'b0;
        wait_outs(1, "samecyc");
        if (outq.size() > 0) check("samecyc_out", outq[0], 7);

        // DC: 1000*4096*(j+1)/2^17.
        pulse_rst();
        for (int k = 0; k < NT; k++) write_coef(k, 18'd4096);
        clear_q();
        for (int j = 0; j < NT; j++) send(24'd1000);
        wait_outs(NT, "dc");
        if (outq.size() == NT) begin
            check("dc_first", outq[0], 31);
            check("dc_final", outq[NT-1], 1000);
        end
        check("dc_err", err, 0);

        // Full-scale input with near-unity coefficients.
        for (int k = 0; k < NT; k++) write_coef(k, 18'd131071);
        clear_q();
        for (int j = 0; j < NT; j++) send(24'd8388607);
        wait_outs(NT, "sat");
        if (outq.size() == NT) check("sat_final", outq[NT-1], SAT_EXP);
        check("sat_err", err, 0);

        // Drop mac_valid at the first predicted result cycle.
        clear_q();
        send(24'd1000);
        repeat (3) @(posedge clk);
        #1;
        check("fault_busy", in_ready, 0);
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        check("fault_err_set", err, 1);
        wait_outs(1, "fault");
        check("fault_err_held", err, 1);
        pulse_rst();
        check("fault_err_clr", err, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fir_tap_sequencer.md
FIR_TAP_SEQUENCER -- requirements
Module: fir_tap_sequencer

Interface
REQ-001 Parameter NTAPS, default 32: number of FIR taps; legal range MAC_LAT..256.
REQ-002 Parameter MAC_LAT, default 3: MAC pipeline latency in cycles, from operand issue to mac_out; legal range 1..8.
REQ-003 Parameter COEF_FRAC, default 17: fractional bits of the coefficients.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 in_data  in  24  signed input sample.
REQ-008 in_valid  in  1  in_data offered.
REQ-009 in_ready  out  1  block can accept a sample.
REQ-010 coef_we / coef_addr / coef_data  in  1 / clog2(NTAPS) / 18  signed coefficient write port.
REQ-011 mac_a  out  25  sign-extended delay-line sample to the MAC.
REQ-012 mac_b  out  18  coefficient to the MAC.
REQ-013 mac_c  out  48  partial-sum addend to the MAC.
REQ-014 mac_out  in  48  MAC result, mac_a*mac_b+mac_c, delayed by MAC_LAT.
REQ-015 mac_valid  in  1  MAC result-valid flag.
REQ-016 out_data  out  24  signed filter output.
REQ-017 out_valid  out  1  one-cycle output strobe.
REQ-018 err  out  1  sticky MAC-valid mismatch flag.

Function
REQ-019 FSM states: IDLE, RUN, DRAIN, OUT; in_ready=1 only in IDLE.
REQ-020 IDLE: on in_valid&&in_ready at edge E0, write in_data to delay line[wr_ptr], advance wr_ptr mod NTAPS, go to RUN.
REQ-021 RUN: in cycle k+1 after E0 (k=0..NTAPS-1), issue mac_a=sext(sample[newest-k mod NTAPS]) and mac_b=coef[k], with no bubbles.
REQ-022 mac_c=0 for k<MAC_LAT; otherwise mac_c=mac_out of the same cycle (interleaved MAC_LAT partial sums).
REQ-023 Outside RUN, mac_a, mac_b and mac_c SHALL be 0.
REQ-024 DRAIN: sum the MAC_LAT mac_out values of cycles NTAPS+1..NTAPS+MAC_LAT into a 48-bit acc (wrap on overflow).
REQ-025 OUT (cycle NTAPS+MAC_LAT+1): out_valid=1 for exactly one cycle, out_data held until the next OUT, then return to IDLE.
REQ-026 Latency: in_ready is high again in the cycle after OUT; throughput is one sample per NTAPS+MAC_LAT+2 cycles.
REQ-027 An internal MAC_LAT-deep issue shift register predicts result cycles; mac_valid differing from the prediction in any cycle SHALL set err, which holds until rst.
REQ-028 coef_we is honoured only in IDLE and ignored in other states.
REQ-029 A coef_we and a sample acceptance in the same IDLE cycle both take effect; the run uses the new coefficient.
REQ-030 wr_ptr wraps NTAPS-1 -> 0; tap indexing wraps modulo NTAPS.
REQ-031 in_valid outside IDLE is not accepted; the upstream stage holds the sample.

Reset
REQ-032 rst SHALL force: state=IDLE, wr_ptr=0, delay line all 0, acc=0, out_data=0, out_valid=0, err=0, mac_a/b/c=0, in_ready=1 in the following cycle.
REQ-033 rst mid-RUN or mid-DRAIN aborts the computation with no out_valid; late MAC results are ignored and do not set err.
REQ-034 Coefficient storage SHALL NOT be cleared by rst.

Configuration
REQ-035 Macro FIR_ROUND_SAT_EN defined: out_data = round-half-up of acc>>>COEF_FRAC, saturated to [-2^23, 2^23-1].
REQ-036 Macro FIR_ROUND_SAT_EN undefined: out_data = acc[COEF_FRAC+23:COEF_FRAC], truncated, no saturation.

Verification
REQ-037 Impulse: coef[k]=k+1, in_data=131072 then NTAPS-1 zeros -> out_data sequence 1,2,...,NTAPS; out_valid spacing NTAPS+MAC_LAT+2 cycles.
REQ-038 DC: all coef=4096, NTAPS samples of 1000 -> final out_data=(32*4096*1000)>>17=1000 (NTAPS=32).
REQ-039 Saturation with macro: all coef=131071, in_data=8388607 sustained -> out_data=8388607; without macro -> truncated wrap value.
REQ-040 Reset: assert rst at RUN tap 10 -> no out_valid, in_ready=1 next cycle, next impulse output identical to the first-run result.
REQ-041 Handshake/config: in_valid held high during RUN -> exactly one acceptance per frame; coef_we in RUN -> coefficient unchanged.
REQ-042 Fault: force mac_valid low at one predicted cycle -> err=1 and held until rst.
